// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: 128 KiB RAM, UART TX FIFO / RX holding register, and program-stop sequencing.
// Define MEM_IO_CYCLE_COUNTER_EN to build the free-running cycle counter and its snapshot readout at 0x30004-0x30007.
//
// Stop sequencer states:
//   state    | meaning
//   ST_RUN   | normal operation, no stop requested
//   ST_DRAIN | stop byte queued, waiting for the TX FIFO to empty
//   ST_DONE  | stop byte fully transmitted; program_done held until reset
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done
);

    localparam int TX_DEPTH = 2 ** TX_DEPTH_LOG2;
    localparam int RAM_SIZE = 2 ** RAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } stop_state_t;

    logic                      is_io;
    logic [2:0]                io_sel;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                      wr_ram;
    logic                      wr_tx;
    logic                      wr_stop;
    logic                      rd_rx;
    logic                      unused_addr_bits;

    assign is_io            = (mem_a[17:16] == 2'b11);
    assign io_sel           = mem_a[2:0];
    assign ram_addr         = mem_a[RAM_ADDR_WIDTH-1:0];
    assign wr_ram           = mem_wr && !is_io;
    assign wr_tx            = mem_wr && is_io && (io_sel == 3'd0);
    assign wr_stop          = mem_wr && is_io && (io_sel == 3'd4);
    assign rd_rx            = !mem_wr && is_io && (io_sel == 3'd0);
    assign unused_addr_bits = ^mem_a[31:18];

    logic [7:0] ram [RAM_SIZE];

    always_ff @(posedge clk_in) begin
        if (wr_ram) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]               tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [TX_DEPTH_LOG2:0]   tx_count;
    logic                     tx_full;
    logic                     tx_push_req;
    logic                     tx_push;
    logic                     tx_pop;
    logic [7:0]               tx_push_byte;

    // The stop byte is 0x00 and must bypass the zero filter on ordinary writes.
    assign tx_push_req  = (wr_tx && (mem_dout != 8'h00)) || wr_stop;
    assign tx_push_byte = wr_stop ? 8'h00 : mem_dout;
    assign tx_full      = tx_count[TX_DEPTH_LOG2];
    assign tx_pop       = tx_valid && tx_ready;
    assign tx_push      = tx_push_req && (!tx_full || tx_pop);

    assign tx_valid       = (tx_count != '0);
    assign tx_data        = tx_mem[tx_rd_ptr];
    assign io_buffer_full = (int'(tx_count) >= (TX_DEPTH - FULL_MARGIN));

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_push_byte;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- RX holding register ----------------
    logic [7:0] rx_hold;
    logic       rx_full;
    logic       rx_capture;

    assign rx_ready   = !rx_full;
    assign rx_capture = rx_valid && !rx_full;

    // A capture always wins over a same-cycle read clear; the read still sees the old (empty) contents.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_hold <= 8'h00;
            rx_full <= 1'b0;
        end else if (rx_capture) begin
            rx_hold <= rx_data;
            rx_full <= 1'b1;
        end else if (rd_rx) begin
            rx_full <= 1'b0;
        end
    end

    // ---------------- Cycle counter ----------------
    logic [7:0] cnt_rd_data;

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;
    // Only the upper three bytes need storing: the low byte is returned on the latching read itself.
    logic [31:8] snap;
    logic        rd_snap;

    assign rd_snap = !mem_wr && is_io && (io_sel == 3'd4);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt <= '0;
            snap      <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rd_snap) begin
                snap <= cycle_cnt[31:8];
            end
        end
    end

    always_comb begin
        cnt_rd_data = 8'h00;
        case (io_sel)
            3'd4:    cnt_rd_data = cycle_cnt[7:0];
            3'd5:    cnt_rd_data = snap[15:8];
            3'd6:    cnt_rd_data = snap[23:16];
            3'd7:    cnt_rd_data = snap[31:24];
            default: cnt_rd_data = 8'h00;
        endcase
    end
`else
    assign cnt_rd_data = 8'h00;
`endif

    // ---------------- Read data ----------------
    logic [7:0] io_rd_data;

    always_comb begin
        io_rd_data = 8'h00;
        case (io_sel)
            3'd0:                   io_rd_data = rx_full ? rx_hold : 8'h00;
            3'd4, 3'd5, 3'd6, 3'd7: io_rd_data = cnt_rd_data;
            default:                io_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (!mem_wr) begin
            mem_din <= is_io ? io_rd_data : ram[ram_addr];
        end
    end

    // ---------------- Stop sequencer ----------------
    stop_state_t stop_state;
    stop_state_t stop_state_nxt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stop_state <= ST_RUN;
        end else begin
            stop_state <= stop_state_nxt;
        end
    end

    always_comb begin
        stop_state_nxt = stop_state;
        case (stop_state)
            ST_RUN:   if (wr_stop) stop_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!tx_valid) stop_state_nxt = ST_DONE;
            ST_DONE:  stop_state_nxt = ST_DONE;
            default:  stop_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        program_done = (stop_state == ST_DONE);
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Responder end of the CPU's byte-wide memory bus: it accepts address, write-enable and write-data from the core's memory controller and returns read data one cycle later. It contains 128 KiB of single-port RAM, the memory-mapped I/O decode at `0x30000`/`0x30004`, a UART transmit FIFO that drives `io_buffer_full`, a one-byte receive holding register, a free-running cycle counter, and program-stop sequencing. It sits between the `cpu` top and the UART/host interface on the board top.

## Interface

Parameters:
- `RAM_ADDR_WIDTH`, 17: RAM is 2^17 bytes and is indexed by `mem_a[16:0]`.
- `TX_DEPTH_LOG2`, 4: the TX FIFO holds 16 entries.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when free entries ≤ `FULL_MARGIN`. This covers in-flight CPU writes.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset is asynchronous and active-high.
- `mem_a` in 32: CPU address. Only bits [17:0] are decoded.
- `mem_wr` in 1: 1 = write, 0 = read. A transaction happens every cycle.
- `mem_dout` in 8: CPU write data.
- `mem_din` out 8: read data, registered.
- `io_buffer_full` out 1: TX FIFO near-full, sent back to the CPU.
- `tx_data` out 8: head byte of the TX FIFO.
- `tx_valid` out 1: TX FIFO is non-empty.
- `tx_ready` in 1: the UART accepts the head byte.
- `rx_data` in 8: incoming UART byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the holding register is empty.
- `program_done` out 1: sticky; the stop byte has been fully transmitted.

## Operation

- **Address decode:**
  - I/O region when `mem_a[17:16]==2'b11`; RAM otherwise.
  - I/O register select uses `mem_a[2:0]`.
- **RAM read:**
  - `mem_din <= ram[mem_a[16:0]]` on the clock edge.
  - RAM contents are not reset.
- **RAM write:**
  - `ram[addr] <= mem_dout` on the clock edge.
  - `mem_din` holds its previous value during a write.
- **I/O `0x30000` write:**
  - Pushes `mem_dout` into the TX FIFO.
  - A byte of `0x00` is ignored.
  - A push when the FIFO is full drops the byte; state is unchanged.
- **I/O `0x30000` read:**
  - Returns the holding-register byte and clears the register.
  - Returns `0x00` if the register is empty.
- **I/O `0x30004` write (stop):**
  - Pushes `0x00` into the TX FIFO, bypassing the zero filter.
  - Sets `stop_pending`.
- **I/O `0x30004`–`0x30007` read (counter):**
  - A read of `0x30004` latches the counter into `snap` and returns `snap[7:0]`.
  - Reads of `+5`, `+6`, `+7` return `snap` bytes 1–3 (little-endian).
  - Any other I/O offset reads `0x00`; writes to it are ignored.
- **Cycle counter:** 32-bit, increments every cycle after reset, wraps at 2^32.
- **TX FIFO:**
  - First-word-fall-through: `tx_data` is the head byte, `tx_valid = count != 0`.
  - Pop on `tx_valid && tx_ready`.
  - Push and pop in the same cycle when full: both are accepted and the count is unchanged.
  - Push when empty: the byte becomes visible on `tx_data` the next cycle.
- **RX path:**
  - Capture `rx_data` when `rx_valid && rx_ready`.
  - A `0x30000` read in the same cycle as a capture returns the old contents (`0x00` if empty), and the new byte is stored.
- **`program_done`:** set when `stop_pending` is set, the FIFO is empty and `tx_valid` is 0. Stays set until reset.
- **Reset values:**
  - `mem_din=0`, `io_buffer_full=0`, `tx_valid=0`, `rx_ready=1` (after reset), `program_done=0`.
  - Counter, `snap`, FIFO pointers, count, `stop_pending` and the RX register are all cleared.
  - Reset asserted mid-transfer drops all queued bytes immediately; outputs take reset values without waiting for a clock edge.

## Timing

- Read latency is one cycle: address in cycle N gives `mem_din` valid after the edge ending cycle N.
- Writes complete on the edge ending the cycle in which they are presented.
- `io_buffer_full` and `tx_valid` are decoded from the registered count, so there is no combinational path from inputs.
- `rx_ready` comes from a register.
- `program_done` rises on the edge after the last pop that empties the FIFO.

## Configuration

- `MEM_IO_CYCLE_COUNTER_EN` defined: the counter and `snap` are built as described.
- Not defined:
  - Counter and `snap` are removed.
  - Reads of `0x30004`–`0x30007` return `0x00`.
  - A write to `0x30004` still performs the stop sequence.

## Test plan

- Write `0x00123←0xA5`, then read `0x00123` in cycle N → `mem_din==0xA5` after edge N. Read `0x1FFFF` after writing `0x3C` → `0x3C`.
- With `tx_ready=1`, write `0x48`, `0x00`, `0x69` to `0x30000` → the UART sees exactly `0x48`, `0x69`.
- With `tx_ready=0`, write 14 bytes → `io_buffer_full=1`. Write 3 more → the 17th is dropped. Raise `tx_ready` → 16 bytes emerge in order and `io_buffer_full` clears once free entries reach 3.
- With the counter enabled, read `0x30004` at counter value 0x0102_0304, then read `+5`, `+6`, `+7` later → `0x04`, `0x03`, `0x02`, `0x01`. With the macro undefined → all four reads return `0x00`.
- Queue 3 bytes, write `0x30004`, then drain → the UART sees the 3 bytes followed by `0x00`, and `program_done` asserts one cycle after the final handshake.
- Assert `rst_in` asynchronously with 5 bytes queued and the RX register full → `tx_valid=0`, `rx_ready=1` and `program_done=0` immediately; a read of `0x30000` after reset returns `0x00`.
